// File: rtl/axi_stb_slv_if.sv
`default_nettype none
// ============================================================================
// Module      : axi_stb_slv_if
// Description : AXI4 write-only bundle (AW/W/B) between the STB write master
//               and the store-path write slave.
//               master modport : drives AW/W payload and bready
//               slave  modport : drives awready, wready, bvalid, bresp
// Revision    : 1.0  initial release
// ============================================================================
interface axi_stb_slv_if #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 128,
  parameter int UR_BYTE_CNT = 16
);
  // Write address channel
  logic                   s_awvalid;
  logic [ADDR_WIDTH-1:0]  s_awaddr;
  logic [7:0]             s_awlen;
  logic [2:0]             s_awsize;
  logic [1:0]             s_awburst;
  logic                   s_awready;
  // Write data channel
  logic                   s_wvalid;
  logic [DATA_WIDTH-1:0]  s_wdata;
  logic [UR_BYTE_CNT-1:0] s_wstrb;
  logic                   s_wlast;
  logic                   s_wready;
  // Write response channel
  logic                   s_bvalid;
  logic [1:0]             s_bresp;
  logic                   s_bready;

  modport master (
    output s_awvalid, s_awaddr, s_awlen, s_awsize, s_awburst,
    output s_wvalid, s_wdata, s_wstrb, s_wlast,
    output s_bready,
    input  s_awready, s_wready, s_bvalid, s_bresp
  );

  modport slave (
    input  s_awvalid, s_awaddr, s_awlen, s_awsize, s_awburst,
    input  s_wvalid, s_wdata, s_wstrb, s_wlast,
    input  s_bready,
    output s_awready, s_wready, s_bvalid, s_bresp
  );
endinterface
`default_nettype wire

// File: rtl/axi_stb_slv.sv
`default_nettype none
// ============================================================================
// Module      : axi_stb_slv
// Description : AXI4 write slave terminating the STB store path. Accepts one
//               burst at a time, writes beats (byte-strobed) into a
//               MEM_DEPTH x DATA_WIDTH store and returns one B per burst.
//               Ports:
//                 clk, rst   : clock, synchronous active-high reset
//                 s_axi      : AW/W/B channels (axi_stb_slv_if.slave)
//                 dbg_raddr  : debug read index
//                 dbg_rdata  : registered debug read data (1-cycle latency)
//               Optional (macro AXI_STB_SLV_STATS_EN):
//                 stat_txn_cnt / stat_err_cnt : saturating B-handshake counts
// Revision    : 1.0  initial release
// ============================================================================
module axi_stb_slv #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 128,
  parameter int UR_BYTE_CNT = 16,
  parameter int MEM_DEPTH   = 256
) (
  input  wire logic                         clk,
  input  wire logic                         rst,
  axi_stb_slv_if.slave                      s_axi,
  input  wire logic [$clog2(MEM_DEPTH)-1:0] dbg_raddr,
  output logic      [DATA_WIDTH-1:0]        dbg_rdata
`ifdef AXI_STB_SLV_STATS_EN
  ,
  output logic      [15:0]                  stat_txn_cnt,
  output logic      [15:0]                  stat_err_cnt
`endif
);

  localparam int         c_IDX_W  = $clog2(MEM_DEPTH);
  localparam logic [1:0] c_OKAY   = 2'b00;
  localparam logic [1:0] c_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DATA = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  // One extra MSB so an INCR burst running off the end is detectable
  // instead of silently wrapping to entry 0.
  logic [c_IDX_W:0]      r_idx;
  logic [7:0]            r_len;
  logic [7:0]            r_beat_cnt;
  logic                  r_fixed;
  logic                  r_err;
  logic [1:0]            r_bresp;

  logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

  logic w_aw_hs, w_w_hs, w_b_hs;
  logic w_aw_err, w_oob, w_beat_last, w_beat_err, w_end, w_we;

  assign w_aw_hs     = s_axi.s_awvalid && (r_state == S_IDLE);
  assign w_w_hs      = s_axi.s_wvalid  && (r_state == S_DATA);
  assign w_b_hs      = s_axi.s_bready  && (r_state == S_RESP);

  // Misaligned, wrong size, reserved burst type, or start beyond the store.
  assign w_aw_err    = (s_axi.s_awaddr[3:0] != 4'd0) ||
                       (s_axi.s_awsize != 3'b100)     ||
                       s_axi.s_awburst[1]             ||
                       (s_axi.s_awaddr[ADDR_WIDTH-1:4+c_IDX_W] != '0);

  assign w_oob       = r_idx[c_IDX_W];
  assign w_beat_last = (r_beat_cnt == r_len);
  // wlast disagreeing with the beat count covers both early and missing last.
  assign w_beat_err  = w_oob || (s_axi.s_wlast != w_beat_last);
  assign w_end       = w_w_hs && (s_axi.s_wlast || w_beat_last);
  assign w_we        = w_w_hs && !r_err && !w_oob && !rst;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    s_axi.s_awready  = 1'b0;
    s_axi.s_wready   = 1'b0;
    s_axi.s_bvalid   = 1'b0;
    s_axi.s_bresp    = r_bresp;
    case (r_state)
      S_IDLE: begin
        s_axi.s_awready = 1'b1;
        if (w_aw_hs) w_state_nxt = S_DATA;
      end
      S_DATA: begin
        s_axi.s_wready = 1'b1;
        if (w_end) w_state_nxt = S_RESP;
      end
      S_RESP: begin
        s_axi.s_bvalid = 1'b1;
        if (w_b_hs) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ------------------------------------------------------ burst tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx      <= '0;
      r_len      <= '0;
      r_beat_cnt <= '0;
      r_fixed    <= 1'b0;
      r_err      <= 1'b0;
      r_bresp    <= c_OKAY;
    end else begin
      if (w_aw_hs) begin
        r_idx      <= {1'b0, s_axi.s_awaddr[4 +: c_IDX_W]};
        r_len      <= s_axi.s_awlen;
        r_beat_cnt <= '0;
        r_fixed    <= (s_axi.s_awburst == 2'b00);
        r_err      <= w_aw_err;
      end
      if (w_w_hs) begin
        r_beat_cnt <= r_beat_cnt + 8'd1;
        if (!r_fixed) r_idx <= r_idx + 1'b1;
        if (w_beat_err) r_err <= 1'b1;
        if (w_end) r_bresp <= (r_err || w_beat_err) ? c_SLVERR : c_OKAY;
      end
    end
  end

  // ------------------------------------------------------------- storage
  always_ff @(posedge clk) begin
    if (w_we) begin
      for (int b = 0; b < UR_BYTE_CNT; b++) begin
        if (s_axi.s_wstrb[b]) begin
          r_mem[r_idx[c_IDX_W-1:0]][b*8 +: 8] <= s_axi.s_wdata[b*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dbg_rdata <= '0;
    end else begin
      dbg_rdata <= r_mem[dbg_raddr];
    end
  end

`ifdef AXI_STB_SLV_STATS_EN
  // --------------------------------------------------------- statistics
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_txn_cnt <= '0;
      stat_err_cnt <= '0;
    end else if (w_b_hs) begin
      if (stat_txn_cnt != 16'hFFFF) stat_txn_cnt <= stat_txn_cnt + 16'd1;
      if ((r_bresp == c_SLVERR) && (stat_err_cnt != 16'hFFFF)) begin
        stat_err_cnt <= stat_err_cnt + 16'd1;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_axi_stb_slv.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_stb_slv
// Description : Directed self-checking bench for axi_stb_slv. Inputs are
//               driven and outputs sampled on the falling clock edge.
// Revision    : 1.0  initial release
// ============================================================================
module tb_axi_stb_slv;
  localparam int AW = 32;
  localparam int DW = 128;
  localparam int SW = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  axi_stb_slv_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .UR_BYTE_CNT(SW)) bus ();

  logic [7:0]    dbg_raddr;
  logic [DW-1:0] dbg_rdata;
`ifdef AXI_STB_SLV_STATS_EN
  logic [15:0]   stat_txn_cnt;
  logic [15:0]   stat_err_cnt;
`endif

  axi_stb_slv #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .UR_BYTE_CNT(SW), .MEM_DEPTH(256)) dut (
    .clk       (clk),
    .rst       (rst),
    .s_axi     (bus),
    .dbg_raddr (dbg_raddr),
    .dbg_rdata (dbg_rdata)
`ifdef AXI_STB_SLV_STATS_EN
    ,
    .stat_txn_cnt (stat_txn_cnt),
    .stat_err_cnt (stat_err_cnt)
`endif
  );

  int tests = 0;
  int fails = 0;
  int exp_txn = 0;
  int exp_err = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // AW handshake; returns at the falling edge after the handshake edge.
  task automatic aw(input logic [31:0] addr, input logic [7:0] len,
                    input logic [2:0] size, input logic [1:0] burst);
    int n = 0;
    @(negedge clk);
    bus.s_awvalid = 1'b1;
    bus.s_awaddr  = addr;
    bus.s_awlen   = len;
    bus.s_awsize  = size;
    bus.s_awburst = burst;
    while (!bus.s_awready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("aw_timeout", bus.s_awready, 1);
    @(negedge clk);
    bus.s_awvalid = 1'b0;
    chk("aw_to_wready", bus.s_wready, 1);
  endtask

  // One W beat starting at the current falling edge.
  task automatic wbeat(input logic [DW-1:0] data, input logic [SW-1:0] strb, input logic last);
    int n = 0;
    bus.s_wvalid = 1'b1;
    bus.s_wdata  = data;
    bus.s_wstrb  = strb;
    bus.s_wlast  = last;
    while (!bus.s_wready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("w_timeout", bus.s_wready, 1);
    @(negedge clk);
    bus.s_wvalid = 1'b0;
    bus.s_wlast  = 1'b0;
  endtask

  // Called at the falling edge right after the last W handshake.
  task automatic bresp(input logic [1:0] exp);
    chk("bvalid_latency", bus.s_bvalid, 1);
    chk("bresp", bus.s_bresp, exp);
    bus.s_bready = 1'b1;
    @(negedge clk);
    bus.s_bready = 1'b0;
    chk("bvalid_clear", bus.s_bvalid, 0);
    chk("awready_back", bus.s_awready, 1);
    exp_txn++;
    if (exp == 2'b10) exp_err++;
  endtask

  task automatic rd(input logic [7:0] idx, input logic [DW-1:0] exp, input string tag);
    dbg_raddr = idx;
    @(negedge clk);
    chk(tag, dbg_rdata, exp);
  endtask

  logic [DW-1:0] d [4];
  logic [DW-1:0] ff_all;
  logic [DW-1:0] a5;
  logic [DW-1:0] base0;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ff_all = '1;
    a5     = {16{8'hA5}};
    base0  = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    for (int i = 0; i < 4; i++) d[i] = {4{32'hDEAD_BEEF ^ i}};

    rst = 1'b1;
    bus.s_awvalid = 0; bus.s_awaddr = 0; bus.s_awlen = 0; bus.s_awsize = 0; bus.s_awburst = 0;
    bus.s_wvalid = 0; bus.s_wdata = 0; bus.s_wstrb = 0; bus.s_wlast = 0; bus.s_bready = 0;
    dbg_raddr = 0;
    repeat (3) @(negedge clk);
    chk("rst_awready", bus.s_awready, 1);
    chk("rst_wready", bus.s_wready, 0);
    chk("rst_bvalid", bus.s_bvalid, 0);
    chk("rst_bresp", bus.s_bresp, 0);
    chk("rst_dbg", dbg_rdata, 0);
    rst = 1'b0;

    // Single beat
    aw(32'h10, 8'd0, 3'b100, 2'b01);
    wbeat(a5, 16'hFFFF, 1'b1);
    bresp(2'b00);
    rd(8'd1, a5, "single_beat");

    // 4-beat INCR
    aw(32'h40, 8'd3, 3'b100, 2'b01);
    for (int i = 0; i < 4; i++) begin
      wbeat(d[i], 16'hFFFF, i == 3);
      if (i < 3) chk("incr_no_early_end", bus.s_bvalid, 0);
    end
    bresp(2'b00);
    for (int i = 0; i < 4; i++) rd(8'(4 + i), d[i], "incr_data");

    // Strobe merge
    aw(32'h20, 8'd0, 3'b100, 2'b01);
    wbeat(ff_all, 16'hFFFF, 1'b1);
    bresp(2'b00);
    aw(32'h20, 8'd0, 3'b100, 2'b01);
    wbeat('0, 16'h00FF, 1'b1);
    bresp(2'b00);
    rd(8'd2, {64'hFFFF_FFFF_FFFF_FFFF, 64'h0}, "strobe_merge");

    // Misaligned address leaves entry 0 alone
    aw(32'h00, 8'd0, 3'b100, 2'b01);
    wbeat(base0, 16'hFFFF, 1'b1);
    bresp(2'b00);
    aw(32'h08, 8'd0, 3'b100, 2'b01);
    wbeat(ff_all, 16'hFFFF, 1'b1);
    bresp(2'b10);
    rd(8'd0, base0, "misaligned_nowrite");

    // INCR off the end: beat 0 to entry 255, beat 1 dropped (no wrap)
    aw(32'hFF0, 8'd1, 3'b100, 2'b01);
    wbeat(d[0], 16'hFFFF, 1'b0);
    wbeat(d[1], 16'hFFFF, 1'b1);
    bresp(2'b10);
    rd(8'd255, d[0], "overrun_last_entry");
    rd(8'd0, base0, "overrun_no_wrap");

    // Early wlast on beat 1 of len=3
    aw(32'h100, 8'd3, 3'b100, 2'b01);
    wbeat(d[2], 16'hFFFF, 1'b0);
    wbeat(d[3], 16'hFFFF, 1'b1);
    bresp(2'b10);
    rd(8'd16, d[2], "early_last_b0");
    rd(8'd17, d[3], "early_last_b1");

    // Missing wlast: burst ends on count anyway
    aw(32'h120, 8'd1, 3'b100, 2'b01);
    wbeat(d[1], 16'hFFFF, 1'b0);
    wbeat(d[0], 16'hFFFF, 1'b0);
    bresp(2'b10);
    rd(8'd19, d[0], "missing_last_b1");

    // Illegal size and reserved burst type
    aw(32'h140, 8'd0, 3'b011, 2'b01);
    wbeat(d[0], 16'hFFFF, 1'b1);
    bresp(2'b10);
    aw(32'h140, 8'd0, 3'b100, 2'b10);
    wbeat(d[0], 16'hFFFF, 1'b1);
    bresp(2'b10);

    // FIXED burst overwrites one entry; neighbour untouched
    aw(32'h210, 8'd0, 3'b100, 2'b01);
    wbeat(a5, 16'hFFFF, 1'b1);
    bresp(2'b00);
    aw(32'h200, 8'd2, 3'b100, 2'b00);
    wbeat(d[0], 16'hFFFF, 1'b0);
    wbeat(d[1], 16'hFFFF, 1'b0);
    wbeat(d[2], 16'hFFFF, 1'b1);
    bresp(2'b00);
    rd(8'd32, d[2], "fixed_entry");
    rd(8'd33, a5, "fixed_neighbour");

    // bready held low: B stable, next AW and stray W stalled
    aw(32'h220, 8'd0, 3'b100, 2'b01);
    wbeat(d[3], 16'h0000, 1'b1);
    bus.s_awvalid = 1'b1; bus.s_awaddr = 32'h230; bus.s_awlen = 0;
    bus.s_awsize = 3'b100; bus.s_awburst = 2'b01;
    bus.s_wvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("hold_bvalid", bus.s_bvalid, 1);
      chk("hold_bresp", bus.s_bresp, 0);
      chk("hold_awready", bus.s_awready, 0);
      chk("hold_wready", bus.s_wready, 0);
      @(negedge clk);
    end
    bus.s_wvalid = 1'b0;
    bus.s_bready = 1'b1;
    @(negedge clk);
    bus.s_bready = 1'b0;
    exp_txn++;
    chk("hold_release_bvalid", bus.s_bvalid, 0);
    chk("hold_release_awready", bus.s_awready, 1);
    @(negedge clk);
    bus.s_awvalid = 1'b0;
    chk("stalled_aw_wready", bus.s_wready, 1);
    wbeat(d[1], 16'hFFFF, 1'b1);
    bresp(2'b00);
    rd(8'd35, d[1], "stalled_aw_data");

    // bready high before bvalid
    aw(32'h240, 8'd0, 3'b100, 2'b01);
    bus.s_bready = 1'b1;
    wbeat(d[2], 16'hFFFF, 1'b1);
    chk("early_bready_bvalid", bus.s_bvalid, 1);
    @(negedge clk);
    bus.s_bready = 1'b0;
    exp_txn++;
    chk("early_bready_done", bus.s_bvalid, 0);

    // Leave SLVERR in the response register, then reset mid-burst
    aw(32'h08, 8'd0, 3'b100, 2'b01);
    wbeat(d[0], 16'hFFFF, 1'b1);
    bresp(2'b10);
`ifdef AXI_STB_SLV_STATS_EN
    chk("stat_txn_pre", stat_txn_cnt, 16'(exp_txn));
    chk("stat_err_pre", stat_err_cnt, 16'(exp_err));
`endif
    dbg_raddr = 8'd1;
    aw(32'h300, 8'd7, 3'b100, 2'b01);
    wbeat(d[0], 16'hFFFF, 1'b0);
    wbeat(d[1], 16'hFFFF, 1'b0);
    bus.s_wvalid = 1'b1; bus.s_wdata = d[2]; bus.s_wstrb = 16'hFFFF;
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_awready", bus.s_awready, 1);
    chk("midrst_wready", bus.s_wready, 0);
    chk("midrst_bvalid", bus.s_bvalid, 0);
    chk("midrst_bresp", bus.s_bresp, 0);
    chk("midrst_dbg", dbg_rdata, 0);
    exp_txn = 0;
    exp_err = 0;
`ifdef AXI_STB_SLV_STATS_EN
    chk("midrst_stat_txn", stat_txn_cnt, 0);
    chk("midrst_stat_err", stat_err_cnt, 0);
`endif
    rst = 1'b0;
    bus.s_wvalid = 1'b0;
    @(negedge clk);
    chk("post_rst_bvalid", bus.s_bvalid, 0);
    rd(8'd48, d[0], "midrst_keep_b0");
    rd(8'd49, d[1], "midrst_keep_b1");

`ifdef AXI_STB_SLV_STATS_EN
    for (int i = 0; i < 3; i++) begin
      aw(32'h400 + 32'(i * 16), 8'd0, 3'b100, 2'b01);
      wbeat(d[i], 16'hFFFF, 1'b1);
      bresp(2'b00);
    end
    aw(32'h404, 8'd0, 3'b100, 2'b01);
    wbeat(d[3], 16'hFFFF, 1'b1);
    bresp(2'b10);
    @(negedge clk);
    chk("stat_txn", stat_txn_cnt, 16'd4);
    chk("stat_err", stat_err_cnt, 16'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/axi_stb_slv.md
Name: axi_stb_slv

Overview:
- AXI4 write-slave (responder) for the store path. Terminates the AW/W/B channels driven by the STB write master.
- Writes accepted beats, with byte strobes applied, into an internal 128-bit-wide store. Returns one B response per burst.
- Provides a registered debug read port so benches and neighbouring blocks can check stored contents.

Parameters:
- ADDR_WIDTH, 32, AXI address width.
- DATA_WIDTH, 128, data width; one beat = 16 bytes.
- UR_BYTE_CNT, 16, strobe width (DATA_WIDTH/8).
- MEM_DEPTH, 256, number of DATA_WIDTH entries; must be a power of two.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- s_awvalid  in  1  address valid.
- s_awaddr  in  ADDR_WIDTH  byte address.
- s_awlen  in  8  beats-1.
- s_awsize  in  3  beat size; only 3'b100 is legal.
- s_awburst  in  2  burst type; 00=FIXED, 01=INCR.
- s_awready  out  1  address ready.
- s_wvalid  in  1  data valid.
- s_wdata  in  DATA_WIDTH  write data.
- s_wstrb  in  UR_BYTE_CNT  byte enables.
- s_wlast  in  1  last beat.
- s_wready  out  1  data ready.
- s_bvalid  out  1  response valid.
- s_bresp  out  2  00=OKAY, 10=SLVERR.
- s_bready  in  1  response ready.
- dbg_raddr  in  log2(MEM_DEPTH)  debug read index.
- dbg_rdata  out  DATA_WIDTH  debug read data.

Behaviour:
- Reset values: s_awready=1, s_wready=0, s_bvalid=0, s_bresp=00, dbg_rdata=0, state=IDLE, all counters and flags cleared.
- Memory contents are not reset.

States:
- IDLE
  - s_awready=1, s_wready=0.
  - On s_awvalid&&s_awready: latch the index s_awaddr[4+:log2(MEM_DEPTH)], len, and burst type. Set beat_cnt=0. Set err flag if any of the following holds:
    - s_awaddr[3:0]!=0
    - s_awsize!=3'b100
    - s_awburst is 10 or 11
    - (s_awaddr>>4) >= MEM_DEPTH
  - Next cycle: s_awready=0, s_wready=1, state=DATA.
- DATA
  - s_wready=1. The slave never accepts W before AW is accepted; s_wready stays 0 outside DATA.
  - Each s_wvalid&&s_wready: if err=0 and index<MEM_DEPTH, write mem[index] byte-wise, byte i updated only when s_wstrb[i]=1.
  - Index update: INCR increments index; FIXED holds it.
  - If INCR runs past MEM_DEPTH-1: no wrap-around. That beat and later beats are dropped and err is set.
  - wstrb=0 beats are accepted and write nothing; this is OKAY.
  - Burst end is the first of two events:
    - s_wlast=1. If beat_cnt!=len (early last), set err.
    - beat_cnt==len with s_wlast=0. Set err; treat as the end anyway.
  - On burst end: s_wready=0 next cycle, s_bvalid=1, s_bresp = err ? 10 : 00, state=RESP.
- RESP
  - Hold s_bvalid and s_bresp stable until s_bready.
  - On handshake: s_bvalid=0 and s_awready=1 next cycle, state=IDLE.
  - Extra W beats arriving in RESP or IDLE are not accepted (wready=0).

Latency and throughput:
- AW handshake to first wready: 1 cycle.
- Last W handshake to bvalid: 1 cycle.
- One outstanding burst. Back-to-back bursts need a minimum of 1 IDLE cycle.
- bready may be high before bvalid rises; the handshake then completes in the first bvalid cycle.

Debug read port:
- dbg_rdata <= mem[dbg_raddr] every cycle (1-cycle latency), independent of state.
- Reading an index written in the same cycle returns old data.

Reset mid-burst:
- Return to IDLE with the reset values above.
- Already-written entries remain. No B response is issued for the aborted burst.

Optional Feature:
- Macro AXI_STB_SLV_STATS_EN.
- Defined: adds outputs stat_txn_cnt (16 bits; B handshakes) and stat_err_cnt (16 bits; B handshakes with SLVERR). Both saturate at 16'hFFFF and are cleared by rst.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Single beat: AW addr=0x10, len=0, INCR, size=100; W data=0xA5..A5, strb=FFFF, wlast=1 -> bresp=00; dbg_raddr=1 returns 0xA5..A5 one cycle later.
- 4-beat INCR: addr=0x40, len=3, data D0..D3 -> entries 4..7 hold D0..D3; wlast accepted only on beat 3; bresp=00.
- Strobe merge: entry 2 preloaded with all-FF bytes; write 0x00.. with strb=0x00FF -> low 8 bytes=00, high 8 bytes=FF.
- Errors:
  - addr=0x08 -> SLVERR, memory unchanged.
  - addr=0xFF0, len=1, INCR, MEM_DEPTH=256 -> beat 0 written to entry 255, beat 1 dropped, SLVERR.
  - early wlast on beat 1 of len=3 -> SLVERR, beats 0..1 written.
- Handshake: hold bready=0 for 5 cycles -> bvalid and bresp stable; next AW stalled (awready=0) until B completes. Assert rst during beat 2 of len=7 -> all outputs at reset values the next cycle.
- STATS_EN: 3 OKAY bursts plus 1 SLVERR burst -> stat_txn_cnt=4, stat_err_cnt=1.
